// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, assembles each 32-bit instruction from four byte reads
// on the unified memory port and presents it to decode until consumed or redirected.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        stallreq_o
);

    localparam logic StFetch   = 1'b0;
    localparam logic StPresent = 1'b1;

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_q, inst_d;
    logic        stallreq_q, stallreq_d;

    logic [31:0] branch_pc;
    logic [31:0] beat_addr;

    assign branch_pc = branch_target_address_i & 32'hFFFF_FFFC;
    assign beat_addr = pc_q + {30'd0, cnt_q};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        req_d      = req_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        pc_out_d   = pc_out_q;
        inst_d     = inst_q;
        stallreq_d = stallreq_q;

        if (branch_flag_i) begin
            // Redirect wins over everything but reset; partial bytes and any ack are dropped.
            state_d    = StFetch;
            pc_d       = branch_pc;
            cnt_d      = 2'd0;
            req_d      = 1'b1;
            addr_d     = branch_pc;
            valid_d    = 1'b0;
            inst_d     = 32'h0;
            stallreq_d = 1'b1;
        end else begin
            unique case (state_q)
                StFetch: begin
                    req_d      = 1'b1;
                    stallreq_d = 1'b1;
                    addr_d     = beat_addr;
                    // Acks only count once the request is actually visible on the port.
                    if (req_q && mem_ack_i) begin
                        if (cnt_q == 2'd3) begin
                            state_d    = StPresent;
                            cnt_d      = 2'd0;
                            req_d      = 1'b0;
                            stallreq_d = 1'b0;
                            valid_d    = 1'b1;
                            pc_out_d   = pc_q;
                            inst_d     = {mem_rdata_i, buf_q};
                            addr_d     = addr_q;
                        end else begin
                            unique case (cnt_q)
                                2'd0:    buf_d[7:0]   = mem_rdata_i;
                                2'd1:    buf_d[15:8]  = mem_rdata_i;
                                default: buf_d[23:16] = mem_rdata_i;
                            endcase
                            cnt_d  = cnt_q + 2'd1;
                            addr_d = beat_addr + 32'd1;
                        end
                    end
                end
                StPresent: begin
                    if (!stall_i) begin
                        state_d    = StFetch;
                        pc_d       = pc_q + 32'd4;
                        req_d      = 1'b1;
                        addr_d     = pc_q + 32'd4;
                        valid_d    = 1'b0;
                        inst_d     = 32'h0;
                        stallreq_d = 1'b1;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            buf_q      <= 24'h0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
            valid_q    <= 1'b0;
            pc_out_q   <= RESET_PC;
            inst_q     <= 32'h0;
            stallreq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            pc_out_q   <= pc_out_d;
            inst_q     <= inst_d;
            stallreq_q <= stallreq_d;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign if_valid_o = valid_q;
    assign pc_o       = pc_out_q;
    assign inst_o     = inst_q;
    assign stallreq_o = stallreq_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory with configurable ack delay, an instruction-stream model
// feeding a scoreboard queue, and a negedge monitor that checks every presentation.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [7:0]  rdata;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stallreq;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_i                 (stall),
        .branch_flag_i           (branch),
        .branch_target_address_i (tgt),
        .mem_req_o               (req),
        .mem_addr_o              (addr),
        .mem_ack_i               (ack),
        .mem_rdata_i             (rdata),
        .if_valid_o              (valid),
        .pc_o                    (pc),
        .inst_o                  (inst),
        .stallreq_o              (stallreq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] cur_pc = RESET_PC;
    int          beats  = 0;
    int          delay_mode = 0;   // <0: random 0..3 idle cycles before each ack
    bit          spurious_en = 1'b0;
    bit          mon_en = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        case (a)
            32'd0:                return 8'h13;
            32'd1, 32'd2, 32'd3:  return 8'h00;
            32'd4:                return 8'hEF;
            32'd5:                return 8'hBE;
            32'd6:                return 8'hAD;
            32'd7:                return 8'hDE;
            default:              return h[31:24];
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: fresh delay per request beat, garbage data and optional stray acks otherwise.
    int wait_cnt = 0;
    bit pending  = 1'b0;
    initial begin
        ack   = 1'b0;
        rdata = 8'h00;
    end
    always @(posedge clk) begin
        #1;
        rdata = 8'($urandom);
        if (req === 1'b1) begin
            if (!pending) begin
                pending  = 1'b1;
                wait_cnt = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
            end
            if (wait_cnt == 0) begin
                ack     = 1'b1;
                rdata   = mem_byte(addr);
                pending = 1'b0;
            end else begin
                ack = 1'b0;
                wait_cnt--;
            end
        end else begin
            pending = 1'b0;
            ack     = spurious_en && ($urandom_range(0, 3) == 0);
        end
    end

    // Reference model: the instruction stream is PC-sequential except for redirects/resets.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_pc = RESET_PC;
            beats  = 0;
            exp_q.push_back({cur_pc, mem_word(cur_pc)});
        end else if (branch) begin
            exp_q.delete();
            cur_pc = tgt & 32'hFFFF_FFFC;
            beats  = 0;
            exp_q.push_back({cur_pc, mem_word(cur_pc)});
        end else if (valid && !stall) begin
            cur_pc = cur_pc + 32'd4;
            beats  = 0;
            exp_q.push_back({cur_pc, mem_word(cur_pc)});
        end else if (req && ack) begin
            beats++;
        end
    end

    // Monitor
    logic        last_rst = 1'b0;
    logic        last_valid = 1'b0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] last_inst = 32'h0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (last_rst) begin
                check("rst_req", req, 0);
                check("rst_addr", addr, 0);
                check("rst_valid", valid, 0);
                check("rst_pc", pc, RESET_PC);
                check("rst_inst", inst, 0);
                check("rst_stallreq", stallreq, 0);
            end else begin
                if (!valid) check("inst_zero_when_invalid", inst, 0);
                check("stallreq_vs_req", stallreq, req);
                if (req) check("req_addr", addr, cur_pc + 32'(beats));
                if (valid && !last_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_present: got pc %h expected none", pc);
                    end else begin
                        e = exp_q.pop_front();
                        n_pops++;
                        check("present_pc", pc, e.pc);
                        check("present_inst", inst, e.inst);
                    end
                end
                if (valid && last_valid) begin
                    check("hold_pc", pc, last_pc);
                    check("hold_inst", inst, last_inst);
                end
            end
        end
        last_rst   = rst;
        last_valid = valid;
        last_pc    = pc;
        last_inst  = inst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 80);
        check(name, valid, 1);
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req && addr == a) && n < 80);
        check(name, addr, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; stall = 1'b1; branch = 1'b0; tgt = 32'h0;
        repeat (2) tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;                          // cycle 0
        @(negedge clk);

        // Immediate acks: requests 0..3 in cycles 1-4, instruction in cycle 5
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_req", req, 1);
            check("t1_addr", addr, k);
        end
        @(negedge clk);
        check("t1_valid", valid, 1);
        check("t1_inst", inst, 32'h0000_0013);
        check("t1_pc", pc, 32'h0);

        // Stall holds the presentation
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_valid", valid, 1);
            check("t3_hold_req", req, 0);
            check("t3_hold_inst", inst, 32'h0000_0013);
        end
        tick();
        stall = 1'b0;
        delay_mode = 2;
        @(negedge clk);
        check("t3_release_valid", valid, 1);
        @(negedge clk);
        check("t3_next_req", req, 1);
        check("t3_next_addr", addr, 32'h4);

        // Two idle cycles before each ack: 12 cycles from first request to valid
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!valid) check("t2_stallreq", stallreq, 1);
        end while (!valid && n < 40);
        check("t2_latency", n, 12);
        check("t2_inst", inst, 32'hDEAD_BEEF);
        check("t2_pc", pc, 32'h4);

        // Redirect after two bytes of the fetch at 8
        wait_addr("t4_two_bytes", 32'hA);
        tick();
        branch = 1'b1; tgt = 32'h100; stall = 1'b1;
        tick();
        branch = 1'b0;
        @(negedge clk);
        check("t4_valid", valid, 0);
        check("t4_req", req, 1);
        check("t4_addr", addr, 32'h100);
        wait_valid("t4_present");
        check("t4_pc", pc, 32'h100);

        // Redirect and stall together while presenting
        tick();
        branch = 1'b1; tgt = 32'h102;
        tick();
        branch = 1'b0;
        @(negedge clk);
        check("t5_valid", valid, 0);
        check("t5_inst", inst, 0);
        check("t5_addr", addr, 32'h100);
        wait_valid("t5_present");
        check("t5_pc", pc, 32'h100);

        // PC wrap, then reset in the middle of a fetch
        tick();
        branch = 1'b1; tgt = 32'hFFFF_FFFC;
        tick();
        branch = 1'b0;
        wait_valid("t6_present");
        check("t6_pc", pc, 32'hFFFF_FFFC);
        tick();
        stall = 1'b0;
        tick();
        stall = 1'b1;
        @(negedge clk);
        check("t6_wrap_req", req, 1);
        check("t6_wrap_addr", addr, 32'h0);
        wait_addr("t6_byte1", 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_req", req, 0);
        check("t6_rst_valid", valid, 0);
        @(negedge clk);
        check("t6_refetch_req", req, 1);
        check("t6_refetch_addr", addr, RESET_PC);

        // Randomized traffic
        delay_mode  = -1;
        spurious_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            stall  = ($urandom_range(0, 2) == 0);
            branch = ($urandom_range(0, 24) == 0);
            tgt    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
            rst    = ($urandom_range(0, 399) == 0);
        end
        tick();
        rst = 1'b0; branch = 1'b0; stall = 1'b0;
        repeat (20) tick();
        n_tests++;
        if (n_pops < 60) begin
            n_fail++;
            $display("FAIL random_presentations: got %0d expected at least 60", n_pops);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
